// File: rtl/sim_pkg.sv
// sim_pkg: types and constants shared by the instruction fetch path.
//   instr_t       - one 32-bit MIPS instruction word
//   fetch_entry_t - a buffered instruction together with the PC it was fetched at
//   NOP_INSTR     - sll $0,$0,0, the canonical MIPS no-op
//   PC_STEP       - byte distance between consecutive sequential instructions
package sim_pkg;

    typedef logic [31:0] instr_t;

    typedef struct packed {
        instr_t      instruction;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam instr_t      NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetch_entry_t with occupancy count.
// Ports:
//   clk, resetN - clock and asynchronous active-low reset
//   push        - write push_entry at the tail (ignored when full or flushing)
//   push_entry  - entry to write
//   pop         - drop the head entry (ignored when empty or flushing)
//   flush       - empty the buffer and rewind both pointers; beats push/pop
//   count       - number of valid entries, 0..DEPTH
//   head        - storage at the read pointer; only meaningful when count != 0
module fetch_fifo
    import sim_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0]   Full   = (PtrW + 1)'(DEPTH);
    localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_push;
    logic            do_pop;

    // Guarded locally too, so the buffer can never overwrite or underflow
    // regardless of what the caller does.
    assign do_push = push && !flush && (count_q != Full);
    assign do_pop  = pop && !flush && (count_q != '0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: its contents are never observed while count is 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    count_in_range: assert property (@(posedge clk) disable iff (!resetN) count_q <= Full);

endmodule

// File: rtl/instruction_fetch_buffer.sv
// instruction_fetch_buffer: receives the instruction stream over valid/ready,
// tags each word with its PC and presents the oldest one to decode.
// Ports:
//   clk, resetN                    - clock and asynchronous active-low reset
//   inValid, inInstruction, inReady - producer handshake
//   outValid, outInstruction, outPc, outReady - decode handshake (outReady low stalls)
//   flush, flushPc                 - discard everything; next accepted word gets flushPc
//   count                          - buffer occupancy
//   retired                        - instructions handed to decode since reset (wraps)
module instruction_fetch_buffer
    import sim_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter instr_t      NOP      = NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   inValid,
    input  logic [31:0]            inInstruction,
    output logic                   inReady,
    output logic                   outValid,
    output logic [31:0]            outInstruction,
    output logic [31:0]            outPc,
    input  logic                   outReady,
    input  logic                   flush,
    input  logic [31:0]            flushPc,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]            retired
);

    localparam logic [$clog2(DEPTH):0] Full = ($clog2(DEPTH) + 1)'(DEPTH);

    logic         push_fire;
    logic         pop_fire;
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic [31:0]  pc_next_q;
    logic [31:0]  retired_q;

    // Readiness depends only on registered occupancy: a pop this cycle does not
    // free a slot for a push in the same cycle.
    assign inReady   = (count != Full) && !flush;
    assign outValid  = (count != '0);
    assign push_fire = inValid && inReady;
    assign pop_fire  = outValid && outReady && !flush;

    assign push_entry = '{instruction: inInstruction, pc: pc_next_q};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetN     (resetN),
        .push       (push_fire),
        .push_entry (push_entry),
        .pop        (pop_fire),
        .flush      (flush),
        .count      (count),
        .head       (head)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pc_next_q <= RESET_PC;
            retired_q <= '0;
        end else begin
            if (flush) begin
                pc_next_q <= flushPc;
            end else if (push_fire) begin
                pc_next_q <= pc_next_q + PC_STEP;
            end
            if (pop_fire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign retired = retired_q;

    // Decode sees a harmless no-op at PC 0 rather than stale storage.
    always_comb begin
        outInstruction = NOP;
        outPc          = '0;
        if (outValid) begin
            outInstruction = head.instruction;
            outPc          = head.pc;
        end
    end

endmodule

// File: doc/instruction_fetch_buffer.md
Name: instruction_fetch_buffer

Overview:
- Processor-side receiver for the instruction stream produced by the simulation driver or a future instruction memory.
- Accepts 32-bit MIPS instructions over a valid/ready handshake and buffers them in a small FIFO.
- Tags each instruction with its PC and presents the head entry to the decode stage, which can stall it.
- Supports a synchronous flush with PC redirect, for branches and jumps resolved downstream.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, ≥2.
- RESET_PC, 32'h0000_0000: PC assigned to the first instruction accepted after reset.
- NOP, 32'h0000_0000: value driven on outInstruction when the buffer is empty (sll $0,$0,0).

Ports:
- clk  input  1  sole clock, rising edge.
- resetN  input  1  asynchronous, active-low reset.
- inValid  input  1  producer has an instruction.
- inInstruction  input  32  instruction word.
- inReady  output  1  buffer can accept this cycle.
- outValid  output  1  head entry valid.
- outInstruction  output  32  head instruction; NOP when empty.
- outPc  output  32  PC of head instruction; 0 when empty.
- outReady  input  1  decode consumes head this cycle (low = stall).
- flush  input  1  discard all entries and redirect.
- flushPc  input  32  PC of next instruction accepted after flush.
- count  output  $clog2(DEPTH)+1  occupancy.
- retired  output  32  total instructions popped since reset.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (resetN=0), applied immediately:
  - count, read pointer, write pointer and retired all go to 0.
  - pcNext = RESET_PC.
  - outValid=0, outInstruction=NOP, outPc=0.
  - inReady=1 once resetN deasserts.
  - Reset mid-stream discards all contents; no partial state survives.
- Push: inValid && inReady at a rising edge.
  - Writes {inInstruction, pcNext} at the write pointer, advances the write pointer mod DEPTH, and sets pcNext += 4 (wraps mod 2^32).
- Pop: outValid && outReady at a rising edge.
  - Advances the read pointer mod DEPTH and increments retired (wraps mod 2^32).
- inReady = (count != DEPTH) && !flush. Combinational from registered state plus flush; no same-cycle bypass when full. A pop does not raise inReady until the next cycle.
- outValid = (count != 0). outInstruction and outPc come from the head entry's storage.
- Latency:
  - An instruction pushed at edge N appears on the outputs after edge N (visible in cycle N+1).
  - There is no combinational path from inInstruction to outInstruction.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Empty: outReady is ignored; retired does not change.
- Full: inValid is ignored and no entry is overwritten.
- Flush, highest priority over push and pop:
  - At the edge with flush=1: count=0, both pointers=0, pcNext=flushPc.
  - Any push or pop attempted that cycle is dropped; retired is not incremented.
  - The next accepted instruction is tagged with flushPc.
  - Flush while empty only reloads pcNext.
- Flush and reset together: reset wins.
- Invariant: 0 ≤ count ≤ DEPTH. The implementation shall carry an assertion for this.

Decomposition:
- Shared package sim_pkg:
  - typedef instr_t (logic [31:0]).
  - typedef fetch_entry_t (struct {instr_t instruction; logic [31:0] pc;}).
  - constant NOP_INSTR.
  - constant PC_STEP = 4.
- Sub-module fetch_fifo: parameterised DEPTH, holds fetch_entry_t, exposes push/pop/flush/count/head.
- Top level owns pcNext, the retired counter, the handshake logic and NOP substitution.

Test Plan:
- Reset, then push 32'h2008_0005 (addi $t0,$0,5) with outReady=0 → next cycle outValid=1, outInstruction=32'h2008_0005, outPc=0, count=1.
- Push 5 instructions with DEPTH=4 and outReady=0 → inReady=0 after the 4th accept. The 5th is held by the producer; count=4, no overwrite.
- Continuous push and pop, outReady=1, 8 instructions → outPc sequence 0,4,...,28; retired=8; count stays ≤1.
- Fill with 3 entries, assert flush with flushPc=32'h0040_0100 and a simultaneous push → count=0, outInstruction=NOP. The next pushed instruction has outPc=32'h0040_0100; retired is unchanged.
- Drive resetN low asynchronously mid-cycle with count=2 → outValid drops before the next clock edge; after release, the first push is tagged RESET_PC.
- Pointer wrap: 10 push/pop cycles at DEPTH=4 with interleaved stalls → order preserved; instructions match the driver's sequence exactly.
